// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first. Oversamples sclk/cs/mosi in the clk domain, deserialises
// mosi into words and serialises a one-entry transmit holding register onto miso.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   sclkDly_q;
    logic                   csDly_q;

    logic sclkS;
    logic csS;
    logic mosiS;
    logic sclkRise;
    logic sclkFall;
    logic csFall;
    logic csRise;

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      bitCnt_q,    bitCnt_d;
    logic [DATA_WIDTH-1:0] rxShift_q,   rxShift_d;
    logic [DATA_WIDTH-1:0] txShift_q,   txShift_d;
    logic [DATA_WIDTH-1:0] rxData_q,    rxData_d;
    logic                  rxValid_q,   rxValid_d;
    logic                  underrun_q,  underrun_d;
    logic                  miso_q,      miso_d;
    logic [DATA_WIDTH-1:0] holdData_q,  holdData_d;
    logic                  holdFull_q,  holdFull_d;
    logic                  load;
    logic                  accept;

    // cs synchronisers reset to the deasserted level so no spurious edge follows reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sclkDly_q  <= 1'b0;
            csDly_q    <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
            sclkDly_q  <= sclkS;
            csDly_q    <= csS;
        end
    end

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign csS      = csSync_q[SYNC_STAGES-1];
    assign mosiS    = mosiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkDly_q;
    assign sclkFall = ~sclkS & sclkDly_q;
    assign csFall   = ~csS & csDly_q;
    assign csRise   = csS & ~csDly_q;

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        if (state_q == IDLE) begin
            if (csFall) begin
                state_d  = ACTIVE;
                bitCnt_d = '0;
                load     = 1'b1;
            end
        end else begin
            // cs release wins over any sclk edge seen in the same cycle
            if (csRise) begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end else if (sclkRise) begin
                rxShift_d = {rxShift_q[DATA_WIDTH-2:0], mosiS};
                bitCnt_d  = bitCnt_q + 1'b1;
                if (bitCnt_q == LAST_BIT) begin
                    rxData_d  = rxShift_d;
                    rxValid_d = 1'b1;
                end
            end else if (sclkFall) begin
                if (bitCnt_q == FULL_CNT) begin
                    load     = 1'b1;
                    bitCnt_d = '0;
                end else begin
                    txShift_d = {txShift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end

        if (load) begin
            txShift_d  = holdFull_q ? holdData_q : '0;
            underrun_d = ~holdFull_q;
        end

        miso_d = (state_d == ACTIVE) ? txShift_d[DATA_WIDTH-1] : 1'b0;
    end

    // A load empties the holding register; a handshake in the same cycle refills it
    always_comb begin
        accept     = tx_valid & ~holdFull_q;
        holdFull_d = holdFull_q;
        holdData_d = holdData_q;
        if (load) begin
            holdFull_d = 1'b0;
        end
        if (accept) begin
            holdFull_d = 1'b1;
            holdData_d = tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            holdData_q <= '0;
            holdFull_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            holdData_q <= holdData_d;
            holdFull_q <= holdFull_d;
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = ~holdFull_q;
    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign busy        = (state_q == ACTIVE);
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: drives a mode-0 master and compares exchanged words,
// received words, underrun pulses and handshake state against a word-level model.
module tb_spi_slave;

    localparam int W     = 8;
    localparam int SYNC  = 2;
    localparam int HALF  = 5;
    localparam int SETUP = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         sclk;
    logic         cs;
    logic         mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         tx_underrun;

    always #5 clk = ~clk;

    spi_slave #(
        .DATA_WIDTH (W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Word-level model of the responder: one holding slot and the last completed word
    logic         modelHoldFull;
    logic [W-1:0] modelHold;
    logic [W-1:0] modelRxData;
    int           modelUnderruns;

    logic [W-1:0] rxSeen[$];
    int           underrunSeen = 0;
    int           longPulses   = 0;
    logic         prevRxValid  = 1'b0;
    logic         prevUnderrun = 1'b0;

    logic [W-1:0] mosiWords[4];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxSeen.push_back(rx_data);
        if (tx_underrun === 1'b1) underrunSeen++;
        if ((rx_valid === 1'b1 && prevRxValid) || (tx_underrun === 1'b1 && prevUnderrun)) longPulses++;
        prevRxValid  = (rx_valid === 1'b1);
        prevUnderrun = (tx_underrun === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic modelLoad(output logic [W-1:0] word);
        word = modelHoldFull ? modelHold : '0;
        if (!modelHoldFull) modelUnderruns++;
        modelHoldFull = 1'b0;
    endtask

    task automatic modelReset();
        modelHoldFull = 1'b0;
        modelHold     = '0;
        modelRxData   = '0;
    endtask

    task automatic pushTx(input logic [W-1:0] val);
        int waitCycles = 0;
        while (tx_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("txReadyBeforePush", tx_ready, 1);
        tx_data  = val;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        modelHoldFull = 1'b1;
        modelHold     = val;
        checkOutput("txReadyAfterPush", tx_ready, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_miso"}, miso, 0);
        checkOutput({tag, "_rxData"}, rx_data, 0);
        checkOutput({tag, "_rxValid"}, rx_valid, 0);
        checkOutput({tag, "_txReady"}, tx_ready, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_underrun"}, tx_underrun, 0);
    endtask

    // Master side: the final sclk fall and the cs release (or reset) happen together
    task automatic applyStimulus(input int nWords, input int lastBits, input logic doPush,
                                 input logic [W-1:0] pushVal, input logic rstAbort);
        logic [W-1:0] expMiso[4];
        logic [W-1:0] expRx[$];
        logic [W-1:0] got;
        int           bits;
        underrunSeen   = 0;
        modelUnderruns = 0;
        rxSeen.delete();
        cs = 1'b0;
        modelLoad(expMiso[0]);
        repeat (SETUP) @(negedge clk);
        checkOutput("busyActive", busy, 1);
        for (int w = 0; w < nWords; w++) begin
            if (w > 0) modelLoad(expMiso[w]);
            bits = (w == nWords - 1) ? lastBits : W;
            got  = '0;
            for (int b = 0; b < bits; b++) begin
                mosi = mosiWords[w][W-1-b];
                if (doPush && w == 0 && b == 0) begin
                    pushTx(pushVal);
                    repeat (HALF - 1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                got[W-1-b] = miso;
                sclk = 1'b1;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
                if (w == nWords - 1 && b == bits - 1) begin
                    if (rstAbort) reset = 1'b1;
                    else cs = 1'b1;
                end
            end
            if (bits == W) begin
                checkOutput($sformatf("misoWord%0d", w), got, expMiso[w]);
                expRx.push_back(mosiWords[w]);
                modelRxData = mosiWords[w];
            end
        end
        if (!rstAbort) begin
            repeat (8) @(negedge clk);
            checkOutput("rxCount", rxSeen.size(), expRx.size());
            for (int i = 0; i < expRx.size() && i < rxSeen.size(); i++)
                checkOutput($sformatf("rxWord%0d", i), rxSeen[i], expRx[i]);
            checkOutput("rxData", rx_data, modelRxData);
            checkOutput("underruns", underrunSeen, modelUnderruns);
            checkOutput("busyIdle", busy, 0);
            checkOutput("misoIdle", miso, 0);
            checkOutput("txReadyIdle", tx_ready, {31'b0, !modelHoldFull});
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nWords;
        int lastBits;
        logic doPush;
        logic [W-1:0] pushVal;

        reset    = 1'b1;
        cs       = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        modelReset();

        // Reset held with the link active
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sclk = ~sclk;
            mosi = 1'($urandom);
            checkResetOutputs($sformatf("reset%0d", i));
        end
        cs   = 1'b1;
        sclk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        checkOutput("postResetBusy", busy, 0);
        checkOutput("postResetReady", tx_ready, 1);

        $display("[TB] single exchange");
        pushTx(8'hA5);
        mosiWords[0] = 8'h3C;
        applyStimulus(1, W, 1'b0, '0, 1'b0);

        $display("[TB] back-to-back");
        pushTx(8'h81);
        mosiWords[0] = 8'h11;
        mosiWords[1] = 8'h22;
        applyStimulus(2, W, 1'b1, 8'h7E, 1'b0);

        $display("[TB] underrun");
        mosiWords[0] = 8'h96;
        applyStimulus(1, W, 1'b0, '0, 1'b0);

        $display("[TB] abort");
        mosiWords[0] = 8'hF0;
        applyStimulus(1, 3, 1'b0, '0, 1'b0);
        mosiWords[0] = 8'h5A;
        applyStimulus(1, W, 1'b0, '0, 1'b0);

        $display("[TB] reset mid-word");
        pushTx(8'h66);
        mosiWords[0] = 8'hE7;
        applyStimulus(1, 5, 1'b0, '0, 1'b1);
        repeat (3) @(negedge clk);
        checkResetOutputs("midReset");
        cs = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        repeat (SYNC + 4) @(negedge clk);
        pushTx(8'h3D);
        mosiWords[0] = 8'hC3;
        applyStimulus(1, W, 1'b0, '0, 1'b0);

        $display("[TB] random transfers");
        for (int t = 0; t < 25; t++) begin
            nWords   = int'($urandom_range(1, 3));
            lastBits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W - 1)) : W;
            doPush   = 1'($urandom);
            pushVal  = W'($urandom);
            for (int w = 0; w < 4; w++) mosiWords[w] = W'($urandom);
            if (!modelHoldFull && $urandom_range(0, 1) == 1) pushTx(W'($urandom));
            applyStimulus(nWords, lastBits, doPush, pushVal, 1'b0);
            repeat ($urandom_range(2, 10)) @(negedge clk);
        end

        checkOutput("singleCyclePulses", longPulses, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
